f8_prefetch_queue: RTL

- Parametrised instruction prefetch unit for the f8 core.
- Fetches two bytes per cycle from the split even/odd byte-banked memory, starting at any byte address, aligned or not.
- Buffers the fetched bytes in a circular byte queue.
- Presents a decode window of up to WINDOW_BYTES bytes, plus its PC, to the decoder.
- Replaces the ad-hoc inst/inst_upper_valid fetch logic. Adds branch redirect/flush and variable-length consume.

---
 rtl/f8_fetch_pkg.sv | 31 +++
 rtl/f8_byte_queue.sv | 68 ++++++
 rtl/f8_prefetch_queue.sv | 100 ++++++++++
 3 files changed

// File: rtl/f8_fetch_pkg.sv
// Shared types and helpers for the f8 instruction prefetch unit.
// Bank address split lives here so fetch and test code agree on it.
package f8_fetch_pkg;

  localparam int F8_ADDR_WIDTH = 16;
  localparam logic [15:0] F8_RESET_VECTOR = 16'h4000;

  typedef logic [7:0] byte_t;
  typedef logic [F8_ADDR_WIDTH-1:0] addr_t;

  typedef struct packed {
    logic [30:0] even;
    logic [30:0] odd;
  } bank_addr_t;

  // Odd start: the odd bank holds the first byte, even bank the next line.
  function automatic bank_addr_t bank_addrs(
    input logic [31:0] addr,
    input int          aw
  );
    logic [30:0] mask;
    logic [30:0] line;
    bank_addr_t  r;
    mask   = 31'((64'd1 << (aw - 1)) - 64'd1);
    line   = addr[31:1];
    r.odd  = line & mask;
    r.even = (line + 31'(addr[0])) & mask;
    return r;
  endfunction

endpackage

// File: rtl/f8_byte_queue.sv
// Circular byte queue: fixed-width push, variable pop, flush.
// Peeks up to POP bytes from the head; empty slots read as zero.
import f8_fetch_pkg::*;

module f8_byte_queue #(
  parameter int DEPTH = 6,
  parameter int PUSH  = 2,
  parameter int POP   = 3,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int NW   = $clog2(POP + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [8*PUSH-1:0] push_data,
  input  logic [NW-1:0]     pop,
  output logic [CW-1:0]     count,
  output logic [8*POP-1:0]  peek
);

  byte_t          mem [DEPTH];
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;

  function automatic logic [PW-1:0] wrap(
    input logic [PW-1:0] p,
    input int            n
  );
    int s;
    s = int'(p) + n;
    if (s >= DEPTH) s = s - DEPTH;
    return PW'(s);
  endfunction

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      for (int k = 0; k < PUSH; k++) begin
        mem[wrap(tail, k)] <= push_data[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= wrap(tail, PUSH);
      head  <= wrap(head, int'(pop));
      count <= CW'(int'(count) - int'(pop) + (push ? PUSH : 0));
    end
  end

  always_comb begin
    peek = '0;
    for (int i = 0; i < POP; i++) begin
      if (i < int'(count)) peek[8*i +: 8] = mem[wrap(head, i)];
    end
  end

endmodule

// File: rtl/f8_prefetch_queue.sv
// f8 instruction prefetch: two-byte banked fetch into a byte queue,
// decode window with PC, redirect flush and variable-length consume.
import f8_fetch_pkg::*;

module f8_prefetch_queue #(
  parameter int ADDR_WIDTH   = 16,
  parameter int QUEUE_DEPTH  = 6,
  parameter int WINDOW_BYTES = 3,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR =
    ADDR_WIDTH'(F8_RESET_VECTOR),
  localparam int CW = $clog2(WINDOW_BYTES + 1),
  localparam int QW = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic [ADDR_WIDTH-2:0]     mem_read_addr_even,
  input  logic [7:0]                mem_read_data_even,
  output logic [ADDR_WIDTH-2:0]     mem_read_addr_odd,
  input  logic [7:0]                mem_read_data_odd,
  output logic                      mem_read_en,
  output logic [8*WINDOW_BYTES-1:0] window,
  output logic [CW-1:0]             window_count,
  output logic [ADDR_WIDTH-1:0]     window_pc,
  input  logic [CW-1:0]             consume,
  input  logic                      redirect,
  input  logic [ADDR_WIDTH-1:0]     redirect_addr,
  output logic                      protocol_error
);

  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  inflight;
  logic                  odd_first;
  logic                  issue;
  logic                  ret;
  logic                  perr_d;
  logic [QW-1:0]         count;
  logic [CW-1:0]         pop_n;
  logic [15:0]           push_data;
  bank_addr_t            bp;
  logic                  unused_bank_hi;

  assign bp = bank_addrs(32'(fetch_addr), ADDR_WIDTH);
  assign mem_read_addr_even = bp.even[ADDR_WIDTH-2:0];
  assign mem_read_addr_odd  = bp.odd[ADDR_WIDTH-2:0];
  assign unused_bank_hi =
    ^{bp.even[30:ADDR_WIDTH-1], bp.odd[30:ADDR_WIDTH-1]};

  // Issue check uses pre-consume count, so it never over-commits the queue.
  always_comb begin
    issue = !redirect &&
      (int'(count) + 2 * int'(inflight) + 2 <= QUEUE_DEPTH);
    window_count = (int'(count) >= WINDOW_BYTES) ?
      CW'(WINDOW_BYTES) : CW'(count);
    perr_d = consume > window_count;
    pop_n  = redirect ? '0 : (perr_d ? window_count : consume);
    ret    = inflight && !redirect;
  end

  assign mem_read_en = issue && !reset;
  assign push_data = odd_first ?
    {mem_read_data_even, mem_read_data_odd} :
    {mem_read_data_odd, mem_read_data_even};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_addr     <= RESET_VECTOR;
      window_pc      <= RESET_VECTOR;
      inflight       <= 1'b0;
      odd_first      <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      protocol_error <= perr_d;
      inflight       <= issue;
      if (issue) odd_first <= fetch_addr[0];
      if (redirect) begin
        fetch_addr <= redirect_addr;
        window_pc  <= redirect_addr;
      end else begin
        if (issue) fetch_addr <= fetch_addr + ADDR_WIDTH'(2);
        window_pc <= window_pc + ADDR_WIDTH'(pop_n);
      end
    end
  end

  f8_byte_queue #(
    .DEPTH (QUEUE_DEPTH),
    .PUSH  (2),
    .POP   (WINDOW_BYTES)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (ret),
    .push_data (push_data),
    .pop       (pop_n),
    .count     (count),
    .peek      (window)
  );

endmodule
